// File: rtl/oddr_pkg.sv
// oddr_serializer shared constants and helpers.
// String options, counter sizing and lane-slice ordering.
package oddr_pkg;

   localparam string ORDER_LSB = "LSB_FIRST";
   localparam string ORDER_MSB = "MSB_FIRST";
   localparam string IDLE_INIT = "INIT";
   localparam string IDLE_HOLD = "HOLD";

   localparam int MAX_LANES = 32;
   localparam int MAX_RATIO = 16;
   localparam int MAX_BITS  = MAX_LANES * MAX_RATIO;

   function automatic int beat_width(input int ratio);
      int w;
      w = $clog2(ratio / 2);
      return (w < 1) ? 1 : w;
   endfunction

   // Bit i of the result is the i-th bit to leave the lane.
   function automatic logic [MAX_RATIO-1:0] lane_slice(
      input logic [MAX_BITS-1:0] data,
      input int                  lane,
      input int                  ratio,
      input bit                  msb_first
   );
      logic [MAX_RATIO-1:0] r;
      logic [MAX_BITS-1:0]  sh;
      r = '0;
      for (int i = 0; i < MAX_RATIO; i++) begin
         if (i < ratio) begin
            sh = data >> (lane * ratio +
                          (msb_first ? ratio - 1 - i : i));
            r[i] = sh[0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/oddr_serializer_if.sv
// Parallel word stream into the DDR serializer.
// Source drives valid/data, serializer answers with ready.
interface oddr_serializer_if #(
   parameter int LANES = 1,
   parameter int RATIO = 4
);

   logic                   S_VALID;
   logic                   S_READY;
   logic [LANES*RATIO-1:0] S_DATA;

   modport master (
      output S_VALID,
      output S_DATA,
      input  S_READY
   );

   modport slave (
      input  S_VALID,
      input  S_DATA,
      output S_READY
   );

endinterface

// File: rtl/oddr_serializer_lane.sv
// One serializer lane: shift register and XOR-encoded
// posedge/negedge output pair.
module oddr_serializer_lane
   import oddr_pkg::*;
#(
   parameter int   RATIO = 4,
   parameter logic INIT  = 1'b0,
   parameter bit   HOLD  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             load,
   input  logic             emit,
   input  logic [RATIO-1:0] din,
   output logic             q
);

   logic [RATIO-1:0] sh_q, sh_d;
   logic             pos_q, pos_d;
   logic             odd_q, odd_d;
   logic             neg_q, neg_d;
   logic             ce_q;
   logic             even_bit, odd_bit;

   always_comb begin
      even_bit = HOLD ? odd_q : INIT;
      odd_bit  = HOLD ? odd_q : INIT;
      if (emit) begin
         even_bit = sh_q[0];
         odd_bit  = sh_q[1];
      end
   end

   // Load wins over shift; the pair being emitted
   // still comes from the old contents.
   always_comb begin
      sh_d  = sh_q;
      pos_d = pos_q;
      odd_d = odd_q;
      if (ce) begin
         if (load) begin
            sh_d = din;
         end else if (emit) begin
            sh_d = sh_q >> 2;
         end
         pos_d = even_bit ^ neg_q;
         odd_d = odd_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         pos_q <= INIT;
         odd_q <= INIT;
         ce_q  <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         pos_q <= pos_d;
         odd_q <= odd_d;
         ce_q  <= ce;
      end
   end

   assign neg_d = ce_q ? (odd_q ^ pos_q) : neg_q;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end

   assign q = pos_q ^ neg_q;

endmodule

// File: rtl/oddr_serializer.sv
// Multi-lane DDR output serializer: shared beat counter,
// handshake, release synchronizer and underrun flag.
module oddr_serializer
   import oddr_pkg::*;
#(
   parameter int    LANES     = 1,
   parameter int    RATIO     = 4,
   parameter logic  INIT      = 1'b0,
   parameter string BIT_ORDER = "LSB_FIRST",
   parameter string IDLE_MODE = "INIT"
) (
   input  logic             C,
   input  logic             R_N,
   input  logic             CE,
   oddr_serializer_if.slave s,
   output logic [LANES-1:0] Q,
   output logic             BUSY,
   output logic             UNDERRUN
);

   localparam int BW   = beat_width(RATIO);
   localparam int HALF = RATIO / 2;
   localparam logic [BW-1:0] LAST = BW'(HALF - 1);
   localparam bit MSB  = (BIT_ORDER == ORDER_MSB);
   localparam bit HOLD = (IDLE_MODE == IDLE_HOLD);

   if (RATIO < 2 || RATIO > MAX_RATIO || (RATIO % 2) != 0)
   begin : g_bad_ratio
      $error("oddr_serializer: RATIO must be even, 2..16");
   end

   if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
      $error("oddr_serializer: LANES must be 1..32");
   end

   if (BIT_ORDER != ORDER_LSB && BIT_ORDER != ORDER_MSB)
   begin : g_bad_order
      $error("oddr_serializer: bad BIT_ORDER");
   end

   if (IDLE_MODE != IDLE_INIT && IDLE_MODE != IDLE_HOLD)
   begin : g_bad_idle
      $error("oddr_serializer: bad IDLE_MODE");
   end

   logic [1:0]    rel_q, rel_d;
   logic          busy_q, busy_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          underrun_q, underrun_d;
   logic          last_beat;
   logic          ready;
   logic          accept;

   assign last_beat = busy_q && (beat_q == LAST);
   assign ready     = CE && rel_q[1] && (!busy_q || last_beat);
   assign accept    = ready && s.S_VALID;
   assign rel_d     = {rel_q[0], 1'b1};

   always_comb begin
      busy_d     = busy_q;
      beat_d     = beat_q;
      underrun_d = 1'b0;
      if (CE) begin
         if (accept) begin
            busy_d = 1'b1;
            beat_d = '0;
         end else if (last_beat) begin
            busy_d     = 1'b0;
            beat_d     = '0;
            underrun_d = 1'b1;
         end else if (busy_q) begin
            beat_d = beat_q + BW'(1);
         end
      end
   end

   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         rel_q      <= '0;
         busy_q     <= 1'b0;
         beat_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         rel_q      <= rel_d;
         busy_q     <= busy_d;
         beat_q     <= beat_d;
         underrun_q <= underrun_d;
      end
   end

   assign s.S_READY = ready;
   assign BUSY      = busy_q;
   assign UNDERRUN  = underrun_q;

   logic [MAX_BITS-1:0] data_ext;
   assign data_ext = MAX_BITS'(s.S_DATA);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [RATIO-1:0] slice;
      assign slice = RATIO'(lane_slice(data_ext, k, RATIO, MSB));

      oddr_serializer_lane #(
         .RATIO (RATIO),
         .INIT  (INIT),
         .HOLD  (HOLD)
      ) u_lane (
         .clk   (C),
         .rst_n (R_N),
         .ce    (CE),
         .load  (accept),
         .emit  (busy_q),
         .din   (slice),
         .q     (Q[k])
      );
   end

endmodule

// File: tb/tb_oddr_serializer.sv
// Directed bench for oddr_serializer: queue model of the
// half-cycle output stream plus hand-computed sequences.
module tb_oddr_serializer;

   logic C = 1'b0;
   always #5 C = ~C;

   logic       ce_a, rn_a;
   logic [1:0] q_a;
   logic       busy_a, und_a;

   logic       ce_b, rn_b;
   logic [0:0] q_b;
   logic       busy_b, und_b;

   oddr_serializer_if #(.LANES(2), .RATIO(4)) ifa ();
   oddr_serializer_if #(.LANES(1), .RATIO(8)) ifb ();

   oddr_serializer #(
      .LANES(2), .RATIO(4), .INIT(1'b1),
      .BIT_ORDER("LSB_FIRST"), .IDLE_MODE("INIT")
   ) dut_a (
      .C(C), .R_N(rn_a), .CE(ce_a), .s(ifa),
      .Q(q_a), .BUSY(busy_a), .UNDERRUN(und_a)
   );

   oddr_serializer #(
      .LANES(1), .RATIO(8), .INIT(1'b0),
      .BIT_ORDER("MSB_FIRST"), .IDLE_MODE("HOLD")
   ) dut_b (
      .C(C), .R_N(rn_b), .CE(ce_b), .s(ifb),
      .Q(q_b), .BUSY(busy_b), .UNDERRUN(und_b)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model of dut_a: pending half-cycle values per word.
   logic [1:0] mq[$];
   logic [1:0] m_hi  = 2'b11;
   logic [1:0] m_lo  = 2'b11;
   int         m_rel = 0;
   bit         m_und = 1'b0;

   always @(posedge C or negedge rn_a) begin
      bit acc;
      int n;
      if (!rn_a) begin
         mq.delete();
         m_hi  = 2'b11;
         m_lo  = 2'b11;
         m_rel = 0;
         m_und = 1'b0;
      end else begin
         n   = mq.size();
         acc = ifa.S_VALID && ce_a && m_rel >= 2 && n <= 2;
         if (ce_a) begin
            if (n > 0) begin
               m_hi = mq.pop_front();
               m_lo = mq.pop_front();
            end else begin
               m_hi = 2'b11;
               m_lo = 2'b11;
            end
            m_und = (n == 2) && !acc;
            if (acc) begin
               for (int i = 0; i < 4; i++)
                  mq.push_back({ifa.S_DATA[4+i], ifa.S_DATA[i]});
            end
         end else begin
            m_hi  = m_lo;
            m_und = 1'b0;
         end
         if (m_rel < 2) m_rel++;
      end
   end

   initial begin : cmp
      forever begin
         @(posedge C); #2;
         chk("m_q_hi", q_a, m_hi);
         @(negedge C); #2;
         chk("m_q_lo", q_a, m_lo);
         chk("m_ready", ifa.S_READY,
             ce_a && m_rel >= 2 && mq.size() <= 2);
         chk("m_busy", busy_a, mq.size() > 0);
         chk("m_und", und_a, m_und);
      end
   end

   task automatic send_a(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      ifa.S_VALID = 1'b1;
      ifa.S_DATA  = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge C);
         if (ifa.S_READY) begin
            @(posedge C); #1;
            ok = 1'b1;
         end
      end
      chk("send_a_done", ok, 1'b1);
   endtask

   logic [1:0] seq_a5 [4];
   logic [1:0] seq_s  [8];
   logic       seq_81 [8];
   bit         ok_b;

   initial begin
      seq_a5 = '{2'b01, 2'b10, 2'b01, 2'b10};
      seq_s  = '{2'b01, 2'b01, 2'b01, 2'b01,
                 2'b10, 2'b10, 2'b10, 2'b10};
      seq_81 = '{1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1};
      ce_a = 1'b1; ce_b = 1'b1;
      ifa.S_VALID = 1'b0; ifa.S_DATA = '0;
      ifb.S_VALID = 1'b0; ifb.S_DATA = '0;
      rn_a = 1'b1; rn_b = 1'b1;
      #1 rn_a = 1'b0; rn_b = 1'b0;

      // reset and release
      repeat (5) begin
         @(negedge C); #2;
         chk("rst_q", q_a, 2'b11);
         chk("rst_ready", ifa.S_READY, 1'b0);
      end
      @(posedge C); #1 rn_a = 1'b1; rn_b = 1'b1;
      @(posedge C);
      @(negedge C); #2 chk("rel_ready_p1", ifa.S_READY, 1'b0);
      @(posedge C);
      @(negedge C); #2 chk("rel_ready_p2", ifa.S_READY, 1'b1);

      // single word
      @(posedge C); #1;
      send_a(8'hA5);
      ifa.S_VALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge C); #2 chk("a5_hi", q_a, seq_a5[2*i]);
         @(negedge C); #2 chk("a5_lo", q_a, seq_a5[2*i+1]);
         chk("a5_und", und_a, i == 1);
         chk("a5_busy", busy_a, i == 0);
      end
      @(posedge C); #2 chk("a5_idle", q_a, 2'b11);
      @(negedge C); #2 chk("a5_und_end", und_a, 1'b0);

      // back-to-back
      @(posedge C); #1;
      send_a(8'h0F);
      send_a(8'hF0);
      ifa.S_VALID = 1'b0;
      #1 chk("s_b2", q_a, seq_s[2]);
      @(negedge C); #2 chk("s_b3", q_a, seq_s[3]);
      chk("s_und_gap", und_a, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge C); #2 chk("s_hi", q_a, seq_s[4+2*i]);
         @(negedge C); #2 chk("s_lo", q_a, seq_s[5+2*i]);
         chk("s_und", und_a, i == 1);
      end
      @(posedge C); #2 chk("s_idle", q_a, 2'b11);

      // CE freeze after bit1
      @(posedge C); #1;
      send_a(8'h95);
      ifa.S_VALID = 1'b0;
      @(posedge C); #2 chk("ce_b0", q_a, 2'b11);
      @(negedge C); #2 chk("ce_b1", q_a, 2'b00);
      #1 ce_a = 1'b0;
      repeat (3) begin
         @(posedge C); #2 chk("ce_hold_hi", q_a, 2'b00);
         @(negedge C); #2 chk("ce_hold_lo", q_a, 2'b00);
         chk("ce_ready", ifa.S_READY, 1'b0);
         chk("ce_und", und_a, 1'b0);
      end
      ce_a = 1'b1;
      @(posedge C); #2 chk("ce_b2", q_a, 2'b01);
      @(negedge C); #2 chk("ce_b3", q_a, 2'b10);
      chk("ce_und_end", und_a, 1'b1);
      @(posedge C); #2 chk("ce_idle", q_a, 2'b11);

      // reset mid-word
      @(posedge C); #1;
      send_a(8'h5A);
      ifa.S_VALID = 1'b0;
      @(posedge C); #2 chk("mr_b0", q_a, 2'b10);
      @(negedge C); #1 rn_a = 1'b0;
      #1 chk("mr_q_init", q_a, 2'b11);
      chk("mr_busy", busy_a, 1'b0);
      repeat (2) @(posedge C);
      #1 rn_a = 1'b1;
      repeat (2) @(posedge C);
      #1;
      send_a(8'hA5);
      ifa.S_VALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge C); #2 chk("mr_hi", q_a, seq_a5[2*i]);
         @(negedge C); #2 chk("mr_lo", q_a, seq_a5[2*i+1]);
      end

      // MSB_FIRST, HOLD, RATIO=8
      @(posedge C); #1;
      ifb.S_VALID = 1'b1;
      ifb.S_DATA  = 8'h81;
      ok_b = 1'b0;
      for (int i = 0; i < 40 && !ok_b; i++) begin
         @(negedge C);
         if (ifb.S_READY) begin
            @(posedge C); #1;
            ok_b = 1'b1;
         end
      end
      chk("send_b_done", ok_b, 1'b1);
      ifb.S_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge C); #2 chk("b_hi", q_b, seq_81[2*i]);
         @(negedge C); #2 chk("b_lo", q_b, seq_81[2*i+1]);
         chk("b_und", und_b, i == 3);
      end
      repeat (3) begin
         @(posedge C); #2 chk("b_hold_hi", q_b, 1'b1);
         @(negedge C); #2 chk("b_hold_lo", q_b, 1'b1);
         chk("b_busy", busy_b, 1'b0);
      end

      repeat (2) @(posedge C);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/oddr_serializer.md
Name: oddr_serializer

Overview:
- Parametrised multi-lane DDR output serializer for Verilator-compatible primitive models; successor to the single-bit DDR output cell.
- Accepts LANES×RATIO-bit parallel words over a valid/ready handshake.
- Shifts out 2 bits per lane per C cycle: one on the high phase, one on the low phase.
- Sits between a fabric-side streaming source and the pad model; replaces hand-instantiated DDR cells plus external shift logic.

Parameters:
- LANES, 1, number of independent output lanes (1..32)
- RATIO, 4, bits per lane per word; even, 2..16
- INIT, 1'b0, Q value under reset and when idle
- BIT_ORDER, "LSB_FIRST", serial order within a lane slice; "LSB_FIRST" or "MSB_FIRST"
- IDLE_MODE, "INIT", underrun output: "INIT" drives INIT, "HOLD" repeats last low-phase bit

Ports:
- C, input, 1, clock; both edges used by output stage
- R_N, input, 1, asynchronous active-low reset
- CE, input, 1, clock enable; low freezes all state
- S_VALID, input, 1, parallel word valid
- S_READY, output, 1, serializer can accept word this cycle
- S_DATA, input, LANES*RATIO, lane k occupies bits [k*RATIO +: RATIO]
- Q, output, LANES, DDR serial outputs
- BUSY, output, 1, a word is being shifted out
- UNDERRUN, output, 1, one-cycle pulse when a word finishes and none follows

Behaviour:
- Reset (R_N=0, async, both posedge and negedge flops):
  - Q=INIT on all lanes, S_READY=0, BUSY=0, UNDERRUN=0.
  - Beat counter and shift registers are cleared.
  - Reset mid-word discards the word; Q goes to INIT immediately, without waiting for a clock edge.
- Reset release: a 2-flop release synchronizer on C. S_READY stays 0 for the first 2 posedges after R_N rises.
- Beat counter: runs 0..RATIO/2-1 while BUSY.
- S_READY = CE & released & (!BUSY | beat==RATIO/2-1). This allows back-to-back words with no gap.
- Accept: the word is accepted when S_VALID & S_READY at a posedge.
  - The word is loaded into the per-lane shift register; BUSY=1 and beat=0 from the next cycle.
- Latency:
  - Word accepted at posedge t.
  - Bit0 of each lane (BIT_ORDER) drives Q from posedge t+1 to negedge t+1.
  - Bit1 drives Q from negedge t+1 to posedge t+2, and so on.
  - The last bit ends at posedge t+1+RATIO/2.
- Output stage per lane:
  - Posedge flop captures the even bit and latches the odd bit for the negedge flop.
  - Q = pos_flop ^ neg_flop, XOR-encoded so the output is glitch-free and needs no clock-gated mux.
  - The negedge flop updates only if CE was high at the preceding posedge.
- Last beat with no S_VALID:
  - BUSY falls and UNDERRUN pulses high for one cycle.
  - Q then follows IDLE_MODE from the next posedge.
- Last beat with S_VALID: the new word's bit0 follows the old word's last bit with no idle phase, and UNDERRUN stays 0.
- Simultaneous accept and final beat: the load takes priority over the shift, and the counter wraps to 0.
- CE=0:
  - Counter, shift registers and both output flops hold.
  - Q holds its current value (last low-phase bit) for the whole period.
  - S_READY=0 and UNDERRUN cannot fire.
  - Resuming CE continues from the frozen beat; no bits are lost or repeated.
- Idle: with BUSY=0 and no accept, Q=INIT (IDLE_MODE "INIT") or the last low-phase bit ("HOLD").
- Parameter checks: RATIO odd or out of range, or an illegal string parameter, causes an elaboration-time $error.

Decomposition:
- Package oddr_pkg holds:
  - the BIT_ORDER/IDLE_MODE string constants;
  - a function for beat counter width, $clog2(RATIO/2) with minimum 1;
  - a lane-slice extraction function honouring BIT_ORDER.
- Sub-module oddr_serializer_lane is replicated LANES times. Each instance holds:
  - the RATIO-bit shift register;
  - the posedge/negedge XOR output pair.
- Shared control (counter, handshake, release synchronizer, UNDERRUN) stays in the top.

Test Plan:
1. Reset and release, LANES=2, RATIO=4, INIT=1: hold R_N=0 for 5 cycles, then release.
   -> Q=2'b11 throughout reset; S_READY=0 for 2 posedges after release, then 1.
2. Single word, LSB_FIRST: S_DATA=8'hA5 accepted at posedge t.
   -> lane0 Q sequence 1,0,1,0 and lane1 Q 0,1,0,1 on half-cycles from posedge t+1.
   -> UNDERRUN pulses in cycle t+2; Q=INIT from posedge t+3.
3. Back-to-back streaming: words 8'h0F, 8'hF0 with S_VALID held high.
   -> continuous 8-bit stream per lane with no idle half-cycle; UNDERRUN=0 between the words.
4. CE freeze: drop CE for 3 cycles after bit1 of a word.
   -> Q holds bit1 for 3 cycles; bits 2,3 follow once CE returns; S_READY=0 while CE=0.
5. Reset mid-word: assert R_N=0 on the negedge during bit1.
   -> Q=INIT immediately; after release the next word starts cleanly at bit0.
6. MSB_FIRST with IDLE_MODE="HOLD", RATIO=8: send 8'h81 on lane0.
   -> Q sequence 1,0,0,0,0,0,0,1; Q stays 1 after the word ends.
